// File: rtl/neuron_pkg.sv
// Shared state encoding, Q-format defaults and the output saturation helper
// for the time-multiplexed neuron.
package neuron_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned FRAC_W_DEF = 16;

   // Widest accumulator and result the saturation helper can handle.
   localparam int unsigned SAT_ACC_W = 160;
   localparam int unsigned SAT_Y_W   = 64;
   localparam int unsigned SAT_RES_W = SAT_Y_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      OUT
   } state_t;

   // Drop the fraction (floor), clamp to data_w bits; {sat, y} in the low data_w+1 bits.
   function automatic logic [SAT_RES_W-1:0] sat_trunc(
      input logic signed [SAT_ACC_W-1:0] acc,
      input int unsigned                 data_w,
      input int unsigned                 frac_w
   );
      logic signed [SAT_ACC_W-1:0] one;
      logic signed [SAT_ACC_W-1:0] r;
      logic signed [SAT_ACC_W-1:0] hi;
      logic signed [SAT_ACC_W-1:0] lo;
      logic signed [SAT_ACC_W-1:0] sel;
      logic [SAT_RES_W-1:0]        mask;
      logic [SAT_RES_W-1:0]        res;
      logic                        clip;
      one  = SAT_ACC_W'(1);
      r    = acc >>> frac_w;
      hi   = (one <<< (data_w - 1)) - one;
      lo   = -hi - one;
      clip = (r > hi) || (r < lo);
      sel  = (r > hi) ? hi : ((r < lo) ? lo : r);
      mask = (SAT_RES_W'(1) << data_w) - SAT_RES_W'(1);
      res  = SAT_RES_W'(sel) & mask;
      if (clip) begin
         res = res | (SAT_RES_W'(1) << data_w);
      end
      return res;
   endfunction

endpackage

// File: rtl/neuron_weight_rf.sv
// Runtime-loadable weight register file: one write port, one async read port,
// cleared by reset.
module neuron_weight_rf #(
   parameter int unsigned N_INPUTS = 8,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data_c
);

   logic [DATA_W-1:0] mem [N_INPUTS];

   // Addresses past N_INPUTS-1 (non-power-of-2 sizes) are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_INPUTS); i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && (32'(wr_addr) < N_INPUTS)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: y = sat(sum x_i*w_i + b) using one MAC, one product
// per cycle, with valid/ready on both sides.
module neuron_mac_seq
   import neuron_pkg::*;
#(
   parameter int unsigned N_INPUTS = 8,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned FRAC_W   = FRAC_W_DEF,
   localparam int unsigned ADDR_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N_INPUTS*DATA_W-1:0]   x_flat,
   input  logic [DATA_W-1:0]            bias,
   input  logic                         w_wr_en,
   input  logic [ADDR_W-1:0]            w_wr_addr,
   input  logic [DATA_W-1:0]            w_wr_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            y,
   output logic                         sat
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(N_INPUTS) + 1;
   localparam int unsigned RES_W  = DATA_W + 1;

   state_t                   state;
   logic signed [DATA_W-1:0] x_q [N_INPUTS];
   logic signed [ACC_W-1:0]  acc;
   logic [ADDR_W-1:0]        idx;
   logic [DATA_W-1:0]        w_rd_c;
   logic signed [PROD_W-1:0] prod_c;
   logic [RES_W-1:0]         res_c;

   // Weights only change while idle; a write in the accept cycle lands before the first MAC.
   neuron_weight_rf #(
      .N_INPUTS(N_INPUTS),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W)
   ) u_weight_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (w_wr_en && (state == IDLE)),
      .wr_addr  (w_wr_addr),
      .wr_data  (w_wr_data),
      .rd_addr  (idx),
      .rd_data_c(w_rd_c)
   );

   assign prod_c = PROD_W'(x_q[idx]) * PROD_W'($signed(w_rd_c));
   assign res_c  = RES_W'(sat_trunc(SAT_ACC_W'(acc), DATA_W, FRAC_W));

   // OUT spends its first cycle latching the saturated result, then holds it until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         y         <= '0;
         sat       <= 1'b0;
         acc       <= '0;
         idx       <= '0;
         for (int i = 0; i < int'(N_INPUTS); i++) begin
            x_q[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_ready && in_valid) begin
                  for (int i = 0; i < int'(N_INPUTS); i++) begin
                     x_q[i] <= x_flat[i*DATA_W +: DATA_W];
                  end
                  acc      <= ACC_W'($signed(bias)) <<< FRAC_W;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= MAC;
               end
            end
            MAC: begin
               acc <= acc + ACC_W'(prod_c);
               idx <= idx + ADDR_W'(1);
               if (idx == ADDR_W'(N_INPUTS - 1)) begin
                  state <= OUT;
               end
            end
            OUT: begin
               if (!out_valid) begin
                  y         <= res_c[DATA_W-1:0];
                  sat       <= res_c[DATA_W];
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: directed Q16.16 cases plus random
// operand sets checked against a wide-integer reference model.
module tb_neuron_mac_seq;

   localparam int unsigned N  = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned FW = 16;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [N*DW-1:0] x_flat;
   logic [DW-1:0] bias;
   logic          w_wr_en;
   logic [AW-1:0] w_wr_addr;
   logic [DW-1:0] w_wr_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] y;
   logic          sat;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [DW-1:0] w_model [N];

   neuron_mac_seq #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(FW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x_flat   (x_flat),
      .bias     (bias),
      .w_wr_en  (w_wr_en),
      .w_wr_addr(w_wr_addr),
      .w_wr_data(w_wr_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .y        (y),
      .sat      (sat)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (n_fail=%0d)", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Exact sum in 128-bit integers, floor divide by 2^FW, clamp to 32-bit range.
   function automatic logic [DW:0] ref_model(input logic [N*DW-1:0] xf, input logic [DW-1:0] b);
      logic signed [127:0] s;
      logic signed [127:0] q;
      s = 128'($signed(b)) * 128'sd65536;
      for (int i = 0; i < int'(N); i++)
         s = s + 128'($signed(xf[i*DW +: DW])) * 128'($signed(w_model[i]));
      q = s / 128'sd65536;
      if (s < 0 && (s % 128'sd65536) != 0) q = q - 1;
      if (q > 128'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
      if (q < -128'sd2147483648) return {1'b1, 32'h8000_0000};
      return {1'b0, q[DW-1:0]};
   endfunction

   function automatic logic [DW-1:0] rnd_small();
      return DW'($signed(18'($urandom())));
   endfunction

   task automatic write_w(input int a, input logic [DW-1:0] d);
      w_wr_en = 1'b1; w_wr_addr = AW'(a); w_wr_data = d;
      step();
      w_wr_en = 1'b0;
      w_model[a] = d;
   endtask

   task automatic write_all(input logic [DW-1:0] d);
      for (int i = 0; i < int'(N); i++) write_w(i, d);
   endtask

   // One operation: accept, optional weight-0 write at edge wr_at (0 = accept edge), handshake.
   task automatic do_op(input logic [N*DW-1:0] xf, input logic [DW-1:0] b, input int wr_at,
                        input logic [DW-1:0] wr_d, output logic [DW-1:0] ry, output logic rs,
                        output int lat, output bit to);
      int n;
      n = 0; to = 1'b0; lat = 0; ry = '0; rs = 1'b0;
      while (!in_ready && n < 40) begin step(); n++; end
      if (!in_ready) begin to = 1'b1; return; end
      x_flat = xf; bias = b; in_valid = 1'b1;
      if (wr_at == 0) begin w_wr_en = 1'b1; w_wr_addr = '0; w_wr_data = wr_d; end
      step();
      in_valid = 1'b0; w_wr_en = 1'b0;
      x_flat = {N{DW'($urandom())}}; bias = DW'($urandom());
      while (!out_valid && lat < 40) begin
         if (wr_at == lat + 1) begin w_wr_en = 1'b1; w_wr_addr = '0; w_wr_data = wr_d; end
         step();
         w_wr_en = 1'b0;
         lat++;
      end
      if (!out_valid) begin to = 1'b1; return; end
      ry = y; rs = sat;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; w_wr_en = 1'b0;
      w_wr_addr = '0; w_wr_data = '0; x_flat = '0; bias = '0;
      for (int i = 0; i < int'(N); i++) w_model[i] = '0;
      #3;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++;
         $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready); end
      n_cmp++; if (y !== '0 || sat !== 1'b0) begin n_fail++;
         $display("FAIL reset_y: y=%h sat=%b want 0 0", y, sat); end
      #9 rst_n = 1'b1;
      step(); step();
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_ready: in_ready=%b want 1", in_ready); end
   endtask

   task automatic test_basic();
      logic [N*DW-1:0] xf; logic [DW-1:0] ry; logic rs; int lat; bit to;
      write_all(32'h0001_0000);
      for (int i = 0; i < int'(N); i++) xf[i*DW +: DW] = DW'((i + 1) << 16);
      do_op(xf, 32'h0000_8000, -1, '0, ry, rs, lat, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL basic_timeout: got timeout want result"); end
      n_cmp++; if (ry !== 32'h0024_8000 || rs !== 1'b0) begin n_fail++;
         $display("FAIL basic_y: got %h/%b want 00248000/0", ry, rs); end
      n_cmp++; if (lat != 9) begin n_fail++; $display("FAIL basic_lat: got %0d want 9", lat); end
   endtask

   task automatic test_signed();
      logic [N*DW-1:0] xf; logic [DW-1:0] ry; logic rs; int lat; bit to;
      write_all('0);
      write_w(0, 32'hFFFE_0000);
      xf = {N{DW'($urandom())}};
      xf[DW-1:0] = 32'h0003_0000;
      do_op(xf, '0, -1, '0, ry, rs, lat, to);
      n_cmp++; if (to || ry !== 32'hFFFA_0000 || rs !== 1'b0) begin n_fail++;
         $display("FAIL signed_neg: got %h/%b to=%0b want fffa0000/0", ry, rs, to); end
      write_w(0, 32'hFFFF_8000);
      xf[DW-1:0] = 32'h0000_0001;
      do_op(xf, '0, -1, '0, ry, rs, lat, to);
      n_cmp++; if (to || ry !== 32'hFFFF_FFFF || rs !== 1'b0) begin n_fail++;
         $display("FAIL signed_floor: got %h/%b to=%0b want ffffffff/0", ry, rs, to); end
   endtask

   task automatic test_saturation();
      logic [DW-1:0] ry; logic rs; int lat; bit to;
      write_all(32'h7FFF_0000);
      do_op({N{32'h7FFF_0000}}, '0, -1, '0, ry, rs, lat, to);
      n_cmp++; if (to || ry !== 32'h7FFF_FFFF || rs !== 1'b1) begin n_fail++;
         $display("FAIL sat_max: got %h/%b to=%0b want 7fffffff/1", ry, rs, to); end
      write_all(32'h8000_0000);
      do_op({N{32'h7FFF_0000}}, '0, -1, '0, ry, rs, lat, to);
      n_cmp++; if (to || ry !== 32'h8000_0000 || rs !== 1'b1) begin n_fail++;
         $display("FAIL sat_min: got %h/%b to=%0b want 80000000/1", ry, rs, to); end
   endtask

   task automatic test_backpressure();
      logic [N*DW-1:0] xf; logic [N*DW-1:0] xf2; logic [DW-1:0] b; logic [DW-1:0] ry;
      logic [DW:0] exp; logic [DW-1:0] y0; logic s0, rs; int lat, n; bit to;
      for (int i = 0; i < int'(N); i++) begin
         write_w(i, rnd_small());
         xf[i*DW +: DW] = rnd_small(); xf2[i*DW +: DW] = rnd_small();
      end
      xf2[2*DW-1:DW] = 32'h0003_0000;
      b = rnd_small();
      exp = ref_model(xf, b);
      n = 0;
      while (!in_ready && n < 40) begin step(); n++; end
      x_flat = xf; bias = b; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin step(); n++; end
      y0 = y; s0 = sat;
      n_cmp++; if (out_valid !== 1'b1 || y0 !== exp[DW-1:0] || s0 !== exp[DW]) begin n_fail++;
         $display("FAIL bp_first: got %h/%b valid=%b want %h/%b", y0, s0, out_valid, exp[DW-1:0], exp[DW]); end
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; x_flat = {N{DW'($urandom())}}; bias = DW'($urandom());
         w_wr_en = 1'b1; w_wr_addr = AW'(1); w_wr_data = 32'h1234_5678;
         step();
         n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== y0 || sat !== s0) begin n_fail++;
            $display("FAIL bp_hold%0d: valid=%b rdy=%b y=%h sat=%b want 1 0 %h %b", c, out_valid, in_ready, y, sat, y0, s0); end
      end
      w_wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
         $display("FAIL bp_release: valid=%b rdy=%b want 0 1", out_valid, in_ready); end
      exp = ref_model(xf2, b);
      do_op(xf2, b, -1, '0, ry, rs, lat, to);
      n_cmp++; if (to || ry !== exp[DW-1:0] || rs !== exp[DW]) begin n_fail++;
         $display("FAIL bp_next: got %h/%b to=%0b want %h/%b", ry, rs, to, exp[DW-1:0], exp[DW]); end
   endtask

   task automatic test_weight_write();
      logic [N*DW-1:0] xf; logic [DW-1:0] ry; logic rs; int lat; bit to;
      write_all('0);
      write_w(0, 32'h0001_0000);
      xf = '0; xf[DW-1:0] = 32'h0003_0000;
      do_op(xf, '0, 3, 32'h0002_0000, ry, rs, lat, to);
      n_cmp++; if (to || ry !== 32'h0003_0000 || rs !== 1'b0) begin n_fail++;
         $display("FAIL wr_in_mac: got %h/%b to=%0b want 00030000/0", ry, rs, to); end
      do_op(xf, '0, 0, 32'h0002_0000, ry, rs, lat, to);
      w_model[0] = 32'h0002_0000;
      n_cmp++; if (to || ry !== 32'h0006_0000 || rs !== 1'b0) begin n_fail++;
         $display("FAIL wr_at_accept: got %h/%b to=%0b want 00060000/0", ry, rs, to); end
   endtask

   task automatic test_random();
      logic [N*DW-1:0] xf; logic [DW-1:0] b, ry; logic [DW:0] exp; logic rs;
      int lat, mode, a; bit to;
      for (int it = 0; it < 24; it++) begin
         mode = it % 3;
         for (int k = 0; k < 3; k++) begin
            a = $urandom_range(0, N - 1);
            write_w(a, (mode == 1) ? DW'($urandom()) : rnd_small());
         end
         for (int i = 0; i < int'(N); i++) xf[i*DW +: DW] = (mode == 0) ? rnd_small() : DW'($urandom());
         b = (mode == 2) ? DW'($urandom()) : rnd_small();
         exp = ref_model(xf, b);
         do_op(xf, b, -1, '0, ry, rs, lat, to);
         n_cmp++; if (to || ry !== exp[DW-1:0] || rs !== exp[DW]) begin n_fail++;
            $display("FAIL rand%0d_y: got %h/%b to=%0b want %h/%b", it, ry, rs, to, exp[DW-1:0], exp[DW]); end
         n_cmp++; if (lat != 9) begin n_fail++;
            $display("FAIL rand%0d_lat: got %0d want 9", it, lat); end
      end
   endtask

   task automatic test_mid_reset();
      logic [DW-1:0] ry; logic rs; int lat, n; bit to;
      write_all(32'h0001_0000);
      n = 0;
      while (!in_ready && n < 40) begin step(); n++; end
      x_flat = {N{32'h0002_0000}}; bias = '0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || y !== '0 || sat !== 1'b0) begin n_fail++;
         $display("FAIL midrst_async: valid=%b rdy=%b y=%h sat=%b want 0 0 0 0", out_valid, in_ready, y, sat); end
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < int'(N); i++) w_model[i] = '0;
      do_op({N{DW'($urandom())}}, 32'h0001_0000, -1, '0, ry, rs, lat, to);
      n_cmp++; if (to || ry !== 32'h0001_0000 || rs !== 1'b0 || lat != 9) begin n_fail++;
         $display("FAIL midrst_after: got %h/%b lat=%0d to=%0b want 00010000/0 lat 9", ry, rs, lat, to); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_saturation();
      test_backpressure();
      test_weight_write();
      test_random();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
